// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory-port round-robin arbiter
// and the reusable rotating priority picker.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int MEM_ARB_NUM_CH = 2;
    localparam int MEM_ARB_ADDR_W = 32;
    localparam int MEM_ARB_LINE_W = 256;

    // Id width never drops below one bit, even for a single channel.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating priority encoder: first set request at or above
// ptr_i, wrapping modulo NUM_CH.
module rr_picker #(
    parameter int NUM_CH = 2,
    parameter int ID_W   = 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [ID_W-1:0]   ptr_i,
    output logic              any_req_o,
    output logic [ID_W-1:0]   winner_o
);

    localparam int EXT_W = 1 << (ID_W + 1);

    // Zero padding lets any wrapped index be used directly; slots past
    // NUM_CH read as idle, so ids >= NUM_CH can never win.
    logic [EXT_W-1:0] req_ext;
    assign req_ext   = EXT_W'(req_i);
    assign any_req_o = |req_i;

    always_comb begin
        logic [ID_W:0] idx;
        idx      = '0;
        winner_o = '0;
        // Walk from farthest to nearest so the closest requester to ptr_i wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_i} + (ID_W + 1)'(i);
            if (idx >= (ID_W + 1)'(NUM_CH)) begin
                idx = idx - (ID_W + 1)'(NUM_CH);
            end
            if (req_ext[idx]) begin
                winner_o = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel round-robin arbiter merging cache-line requests onto one memory
// port. Define MEM_ARB_FIXED_PRIO_EN for strict fixed priority (channel 0 highest).
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = MEM_ARB_NUM_CH,
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int LINE_W = MEM_ARB_LINE_W,
    parameter int ID_W   = id_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic                     pmem_read_m,
    output logic                     pmem_write_m,
    output logic [ADDR_W-1:0]        pmem_address_m,
    output logic [LINE_W-1:0]        pmem_wdata_m,
    input  logic                     pmem_resp_m,
    input  logic [LINE_W-1:0]        pmem_rdata_m,
    output logic [ID_W-1:0]          grant_id
);

    logic [NUM_CH-1:0][ADDR_W-1:0] addr_a;
    logic [NUM_CH-1:0][LINE_W-1:0] wdata_a;
    assign addr_a  = ch_address;
    assign wdata_a = ch_wdata;

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   gnt_q, gnt_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic [NUM_CH-1:0] req;
    logic              any_req;
    logic [ID_W-1:0]   win;
    logic              resp_fire;
    logic [ID_W-1:0]   gnt_next;

    assign req = ch_read | ch_write;

    rr_picker #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (rr_ptr_q),
        .any_req_o (any_req),
        .winner_o  (win)
    );

    assign gnt_next = (gnt_q == ID_W'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        resp_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    gnt_d   = win;
                    rd_d    = ch_read[win];
                    // Read wins when a channel raises both.
                    wr_d    = ch_write[win] & ~ch_read[win];
                    addr_d  = addr_a[win];
                    wdata_d = wdata_a[win];
                end
            end
            BUSY: begin
                if (pmem_resp_m) begin
                    resp_fire = 1'b1;
                    state_d   = IDLE;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    addr_d    = '0;
                    wdata_d   = '0;
                    rr_ptr_d  = gnt_next;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MEM_ARB_FIXED_PRIO_EN
        rr_ptr_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign pmem_read_m    = rd_q;
    assign pmem_write_m   = wr_q;
    assign pmem_address_m = addr_q;
    assign pmem_wdata_m   = wdata_q;
    assign grant_id       = gnt_q;

    assign ch_resp  = resp_fire ? ({{(NUM_CH-1){1'b0}}, 1'b1} << gnt_q) : '0;
    assign ch_rdata = resp_fire ? pmem_rdata_m : '0;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr with four channels; expected memory
// requests and client responses are queued at stimulus time.
module tb_mem_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 256;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    ch_read = '0;
    logic [N-1:0]    ch_write = '0;
    logic [N*AW-1:0] ch_address = '0;
    logic [N*LW-1:0] ch_wdata = '0;
    logic [N-1:0]    ch_resp;
    logic [LW-1:0]   ch_rdata;
    logic            pmem_read_m, pmem_write_m;
    logic [AW-1:0]   pmem_address_m;
    logic [LW-1:0]   pmem_wdata_m;
    logic            pmem_resp_m = 1'b0;
    logic [LW-1:0]   pmem_rdata_m = '0;
    logic [IW-1:0]   grant_id;

    mem_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_read(ch_read), .ch_write(ch_write),
        .ch_address(ch_address), .ch_wdata(ch_wdata),
        .ch_resp(ch_resp), .ch_rdata(ch_rdata),
        .pmem_read_m(pmem_read_m), .pmem_write_m(pmem_write_m),
        .pmem_address_m(pmem_address_m), .pmem_wdata_m(pmem_wdata_m),
        .pmem_resp_m(pmem_resp_m), .pmem_rdata_m(pmem_rdata_m),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [255:0] wd;
        int          t0;
        bit          lat;
        bit          gap;
    } req_t;

    req_t           reqq[$];
    logic [259:0]   rspq[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_resp = 0;

`ifdef MEM_ARB_FIXED_PRIO_EN
    int ord_all[5] = '{0, 0, 0, 0, 0};
    int ord_03[4]  = '{0, 0, 0, 0};
`else
    int ord_all[5] = '{0, 1, 2, 3, 0};
    int ord_03[4]  = '{3, 0, 3, 0};
`endif

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int ch, input logic [31:0] a);
        ch_address[ch*AW +: AW] = a;
    endtask

    task automatic push_req(input int ch, input bit rd, input bit wr, input logic [31:0] a,
                            input logic [255:0] wd, input bit lat, input bit gap);
        req_t e;
        e.ch = ch; e.rd = rd; e.wr = wr; e.addr = a; e.wd = wd;
        e.t0 = cyc; e.lat = lat; e.gap = gap;
        reqq.push_back(e);
    endtask

    // Waits for an active memory request, then answers after dly cycles.
    task automatic serve(input int dly, input logic [255:0] d, input int ch, input logic [N-1:0] drop);
        int n = 0;
        logic [N-1:0] oh;
        while (!(pmem_read_m | pmem_write_m) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            chk("req_timeout", 256'd0, 256'd1);
            return;
        end
        repeat (dly) tick();
        oh = '0;
        oh[ch] = 1'b1;
        rspq.push_back({oh, d});
        pmem_resp_m  = 1'b1;
        pmem_rdata_m = d;
        ch_read  = ch_read & ~drop;
        ch_write = ch_write & ~drop;
        tick();
        pmem_resp_m  = 1'b0;
        pmem_rdata_m = '0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops request expectations on each new memory request and
    // response expectations on each memory completion.
    initial begin
        bit prev = 1'b0;
        bit act;
        req_t e;
        logic [259:0] r;
        forever begin
            @(negedge clk);
            act = pmem_read_m | pmem_write_m;
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (act && !prev) begin
                    if (reqq.size() == 0) begin
                        chk("unexp_req", 256'd1, 256'd0);
                    end else begin
                        e = reqq.pop_front();
                        chk("grant_id", 256'(grant_id), 256'(e.ch));
                        chk("pmem_rd", 256'(pmem_read_m), 256'(e.rd));
                        chk("pmem_wr", 256'(pmem_write_m), 256'(e.wr));
                        chk("pmem_addr", 256'(pmem_address_m), 256'(e.addr));
                        if (e.wr) chk("pmem_wdata", pmem_wdata_m, e.wd);
                        if (e.lat) chk("req_latency", 256'(cyc - e.t0), 256'd1);
                        if (e.gap) chk("req_gap", 256'(cyc - last_resp), 256'd2);
                    end
                end
                prev = act;
                if (pmem_resp_m) begin
                    if (rspq.size() != 0) begin
                        r = rspq.pop_front();
                        chk("ch_resp", 256'(ch_resp), 256'(r[259:256]));
                        chk("ch_rdata", ch_rdata, r[255:0]);
                        last_resp = cyc;
                    end else begin
                        chk("spur_resp", 256'(ch_resp), 256'd0);
                        chk("spur_rdata", ch_rdata, 256'd0);
                    end
                end else if (ch_resp !== '0 || ch_rdata !== '0) begin
                    chk("stray_resp", {ch_resp, ch_rdata[251:0]}, 256'd0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_rd", 256'(pmem_read_m), 256'd0);
        chk("rst_wr", 256'(pmem_write_m), 256'd0);
        chk("rst_addr", 256'(pmem_address_m), 256'd0);
        chk("rst_wdata", pmem_wdata_m, 256'd0);
        chk("rst_resp", 256'(ch_resp), 256'd0);
        chk("rst_rdata", ch_rdata, 256'd0);
        chk("rst_gid", 256'(grant_id), 256'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Single read on channel 1, response four cycles after the request
        set_addr(1, 32'h0000_1000);
        push_req(1, 1, 0, 32'h0000_1000, '0, 1, 0);
        ch_read = 4'b0010;
        serve(4, {32{8'hA5}}, 1, 4'b0010);
        @(negedge clk);
        chk("resp_one_cycle", 256'(ch_resp), 256'd0);
        chk("rd_cleared", 256'(pmem_read_m), 256'd0);
        tick();

        // Asynchronous reset while BUSY
        set_addr(2, 32'h0000_0200);
        push_req(2, 1, 0, 32'h0000_0200, '0, 1, 0);
        ch_read = 4'b0100;
        tick();
        tick();
        chk("busy_before_rst", 256'(pmem_read_m), 256'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rd", 256'(pmem_read_m), 256'd0);
        chk("arst_addr", 256'(pmem_address_m), 256'd0);
        chk("arst_gid", 256'(grant_id), 256'd0);
        chk("arst_resp", 256'(ch_resp), 256'd0);
        ch_read = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 256'(pmem_read_m | pmem_write_m), 256'd0);

        // Contention: all four channels request continuously
        for (int k = 0; k < N; k++) set_addr(k, 32'h1000 * (k + 1));
        for (int i = 0; i < 5; i++)
            push_req(ord_all[i], 1, 0, 32'h1000 * (ord_all[i] + 1), '0, i == 0, i != 0);
        ch_read = 4'b1111;
        for (int i = 0; i < 5; i++)
            serve(2, 256'(32'hC0DE_0000 + i), ord_all[i], (i == 4) ? 4'b1111 : 4'b0000);
        tick();

        // Write path; address change mid-BUSY must not reach memory
        set_addr(2, 32'h0000_0040);
        ch_wdata[2*LW +: LW] = {8{32'hDEAD_BEEF}};
        push_req(2, 0, 1, 32'h0000_0040, {8{32'hDEAD_BEEF}}, 1, 0);
        ch_write = 4'b0100;
        tick();
        set_addr(2, 32'h0000_0080);
        tick();
        chk("addr_hold", 256'(pmem_address_m), 256'h40);
        chk("wdata_hold", pmem_wdata_m, {8{32'hDEAD_BEEF}});
        serve(1, 256'h77, 2, 4'b0100);
        tick();

        // Read and write together: treated as read
        set_addr(0, 32'h0000_0300);
        push_req(0, 1, 0, 32'h0000_0300, '0, 1, 0);
        ch_read  = 4'b0001;
        ch_write = 4'b0001;
        serve(2, {16{16'h5A3C}}, 0, 4'b0001);

        // Spurious memory response in IDLE
        pmem_resp_m  = 1'b1;
        pmem_rdata_m = {64{4'hF}};
        tick();
        pmem_resp_m  = 1'b0;
        pmem_rdata_m = '0;
        repeat (2) tick();

        // Channels 0 and 3 request continuously
        set_addr(0, 32'h0000_A000);
        set_addr(3, 32'h0000_D000);
        for (int i = 0; i < 4; i++)
            push_req(ord_03[i], 1, 0, (ord_03[i] == 0) ? 32'hA000 : 32'hD000, '0, i == 0, i != 0);
        ch_read = 4'b1001;
        for (int i = 0; i < 4; i++)
            serve(2, 256'(32'hBEE0 + i), ord_03[i], (i == 3) ? 4'b1001 : 4'b0000);
        repeat (3) tick();

        chk("req_left", 256'(reqq.size()), 256'd0);
        chk("resp_left", 256'(rspq.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
